// File: rtl/ddr3_wb_arbiter.sv
// Round-robin arbiter sharing the DDR3 controller's pipelined Wishbone port between two masters.
// Requests are registered downstream; an in-order ID FIFO steers each ack back to its issuer.
module ddr3_wb_arbiter #(
  parameter int ADDR_BITS       = 24,
  parameter int DATA_BITS       = 128,
  parameter int SEL_BITS        = DATA_BITS / 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_m0_stb,
  input  logic                 i_m0_we,
  input  logic [ADDR_BITS-1:0] i_m0_addr,
  input  logic [DATA_BITS-1:0] i_m0_data,
  input  logic [SEL_BITS-1:0]  i_m0_sel,
  output logic                 o_m0_stall,
  output logic                 o_m0_ack,
  output logic [DATA_BITS-1:0] o_m0_data,
  input  logic                 i_m1_stb,
  input  logic                 i_m1_we,
  input  logic [ADDR_BITS-1:0] i_m1_addr,
  input  logic [DATA_BITS-1:0] i_m1_data,
  input  logic [SEL_BITS-1:0]  i_m1_sel,
  output logic                 o_m1_stall,
  output logic                 o_m1_ack,
  output logic [DATA_BITS-1:0] o_m1_data,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [ADDR_BITS-1:0] o_wb_addr,
  output logic [DATA_BITS-1:0] o_wb_data,
  output logic [SEL_BITS-1:0]  o_wb_sel,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_ack,
  input  logic [DATA_BITS-1:0] i_wb_data,
  output logic                 o_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  logic             id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             last_grant;

  logic             pop;
  logic             room;
  logic             slot_free;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             acc_id;
  logic             head_id;
  logic             stb_next;
  logic [CNT_W-1:0] count_next;

  // Arbitration and FIFO bookkeeping for the current cycle
  always_comb begin
    head_id    = id_fifo[head];
    pop        = i_wb_ack && (count != '0);
    room       = (count < FULL_CNT) || pop;
    slot_free  = !o_wb_stb || !i_wb_stall;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (slot_free && room && !i_rst) begin
      if (i_m0_stb && i_m1_stb) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = i_m0_stb;
        grant1 = i_m1_stb;
      end
    end
    accept     = grant0 || grant1;
    acc_id     = grant1;
    stb_next   = accept ? 1'b1 : (slot_free ? 1'b0 : o_wb_stb);
    count_next = count + CNT_W'(accept) - CNT_W'(pop);
  end

  assign o_m0_stall = !grant0;
  assign o_m1_stall = !grant1;

  // Registered downstream request, ack routing and FIFO pointers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_cyc   <= 1'b0;
      o_wb_stb   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_addr  <= '0;
      o_wb_data  <= '0;
      o_wb_sel   <= '0;
      o_m0_ack   <= 1'b0;
      o_m1_ack   <= 1'b0;
      o_m0_data  <= '0;
      o_m1_data  <= '0;
      o_err      <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      o_wb_stb <= stb_next;
      o_wb_cyc <= stb_next || (count_next != '0);
      count    <= count_next;
      if (accept) begin
        o_wb_we    <= acc_id ? i_m1_we   : i_m0_we;
        o_wb_addr  <= acc_id ? i_m1_addr : i_m0_addr;
        o_wb_data  <= acc_id ? i_m1_data : i_m0_data;
        o_wb_sel   <= acc_id ? i_m1_sel  : i_m0_sel;
        tail       <= tail + 1'b1;
        last_grant <= acc_id;
      end
      if (pop)
        head <= head + 1'b1;
      o_m0_ack <= pop && !head_id;
      o_m1_ack <= pop && head_id;
      if (pop && !head_id)
        o_m0_data <= i_wb_data;
      if (pop && head_id)
        o_m1_data <= i_wb_data;
      if (i_wb_ack && (count == '0))
        o_err <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read once written
  always_ff @(posedge i_clk) begin
    if (accept)
      id_fifo[tail] <= acc_id;
  end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Directed and randomized bench for ddr3_wb_arbiter against a queue-based transaction model.
module tb_ddr3_wb_arbiter;
  localparam int AW = 24;
  localparam int DW = 128;
  localparam int SW = 16;
  localparam int MO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          m0_stb = 0, m0_we = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [SW-1:0] m0_sel = '0, m1_sel = '0;
  logic          m0_stall, m0_ack, m1_stall, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata;
  logic [SW-1:0] wb_sel;
  logic          wb_stall = 0, wb_ack = 0;
  logic [DW-1:0] wb_rdata = '0;
  logic          err;

  ddr3_wb_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .SEL_BITS(SW), .MAX_OUTSTANDING(MO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_data(m0_wdata),
    .i_m0_sel(m0_sel), .o_m0_stall(m0_stall), .o_m0_ack(m0_ack), .o_m0_data(m0_rdata),
    .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_data(m1_wdata),
    .i_m1_sel(m1_sel), .o_m1_stall(m1_stall), .o_m1_ack(m1_ack), .o_m1_data(m1_rdata),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
    .o_wb_data(wb_wdata), .o_wb_sel(wb_sel), .i_wb_stall(wb_stall), .i_wb_ack(wb_ack),
    .i_wb_data(wb_rdata), .o_err(err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: expected downstream request plus a queue of issuer IDs
  int            q[$];
  int            m_last;
  int            dut_grant;
  logic          m_stb, m_cyc, m_we, m_ack0, m_ack1, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_d0, m_d1;
  logic [SW-1:0] m_sel;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = 1;
    m_stb = 0; m_cyc = 0; m_we = 0; m_ack0 = 0; m_ack1 = 0; m_err = 0;
    m_addr = '0; m_data = '0; m_d0 = '0; m_d1 = '0; m_sel = '0;
  endtask

  task automatic cycle();
    bit pop, sf, room;
    int sz, g;
    @(negedge clk);
    sz   = q.size();
    pop  = wb_ack && (sz > 0);
    sf   = !m_stb || !wb_stall;
    room = (sz < MO) || pop;
    g = -1;
    if (!rst && sf && room) begin
      if (m0_stb && m1_stb) g = (m_last == 0) ? 1 : 0;
      else if (m0_stb)      g = 0;
      else if (m1_stb)      g = 1;
    end
    dut_grant = !m0_stall ? 0 : (!m1_stall ? 1 : -1);
    chk("m0_stall", m0_stall, g != 0);
    chk("m1_stall", m1_stall, g != 1);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_ack0 = 0;
      m_ack1 = 0;
      if (wb_ack && sz == 0) m_err = 1;
      if (pop) begin
        if (q.pop_front() == 0) begin m_ack0 = 1; m_d0 = wb_rdata; end
        else begin m_ack1 = 1; m_d1 = wb_rdata; end
      end
      if (g == 0) begin
        m_stb = 1; m_we = m0_we; m_addr = m0_addr; m_data = m0_wdata; m_sel = m0_sel;
      end else if (g == 1) begin
        m_stb = 1; m_we = m1_we; m_addr = m1_addr; m_data = m1_wdata; m_sel = m1_sel;
      end else if (sf) begin
        m_stb = 0;
      end
      if (g >= 0) begin q.push_back(g); m_last = g; end
      m_cyc = m_stb || (q.size() != 0);
    end
    chk("wb_stb", wb_stb, m_stb);
    chk("wb_cyc", wb_cyc, m_cyc);
    chk("wb_we", wb_we, m_we);
    chk("wb_addr", wb_addr, m_addr);
    chk("wb_data", wb_wdata, m_data);
    chk("wb_sel", wb_sel, m_sel);
    chk("m0_ack", m0_ack, m_ack0);
    chk("m1_ack", m1_ack, m_ack1);
    chk("m0_data", m0_rdata, m_d0);
    chk("m1_data", m1_rdata, m_d1);
    chk("err", err, m_err);
  endtask

  task automatic idle();
    m0_stb = 0; m1_stb = 0; wb_ack = 0; wb_stall = 0; rst = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    rst = 0;
  endtask

  task automatic rand_fields();
    m0_we = 1'($urandom); m1_we = 1'($urandom);
    m0_addr = AW'($urandom); m1_addr = AW'($urandom);
    m0_wdata = {$urandom, $urandom, $urandom, $urandom};
    m1_wdata = {$urandom, $urandom, $urandom, $urandom};
    m0_sel = SW'($urandom); m1_sel = SW'($urandom);
    wb_rdata = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    model_reset();
    // Reset held: stalls high, outputs zero
    rst = 1; m0_stb = 1; m1_stb = 1;
    cycle();
    cycle();
    chk("rst_m0_stall", m0_stall, 1'b1);
    idle();

    // Single M0 write, then its ack
    m0_stb = 1; m0_we = 1; m0_addr = 24'h000010; m0_wdata = {16{8'hA5}}; m0_sel = '1;
    cycle();
    chk("t1_grant", dut_grant, 0);
    m0_stb = 0;
    cycle();
    chk("t1_wb_addr", wb_addr, 24'h000010);
    wb_ack = 1; wb_rdata = {4{32'h1234_5678}};
    cycle();
    wb_ack = 0;
    chk("t1_m0_ack", m0_ack, 1'b1);
    chk("t1_m1_ack", m1_ack, 1'b0);
    chk("t1_m0_data", m0_rdata, {4{32'h1234_5678}});
    cycle();
    chk("t1_ack_pulse", m0_ack, 1'b0);

    // Both masters held: strict alternation starting with M0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      m0_stb = 1; m1_stb = 1; rand_fields();
      cycle();
      chk("t2_order", dut_grant, i % 2);
    end
    m0_stb = 0; m1_stb = 0;
    for (int i = 0; i < 6; i++) begin
      wb_ack = 1; wb_rdata = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    wb_ack = 0;
    cycle();
    chk("t2_cyc_drop", wb_cyc, 1'b0);

    // Downstream stall holds the request and blocks both masters
    do_reset();
    m0_stb = 1; m0_we = 0; m0_addr = 24'h000300;
    cycle();
    wb_stall = 1; m1_stb = 1; m1_addr = 24'h000777; m0_addr = 24'h000555;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_blocked", dut_grant, -1);
      chk("t3_hold", wb_addr, 24'h000300);
    end
    wb_stall = 0;
    cycle();
    chk("t3_resume", dut_grant, 1);
    m0_stb = 0; m1_stb = 0;
    cycle();
    chk("t3_new_addr", wb_addr, 24'h000777);
    for (int i = 0; i < 2; i++) begin wb_ack = 1; cycle(); end
    wb_ack = 0;

    // Fill the ID FIFO; an ack lets one more in on the same cycle
    do_reset();
    for (int i = 0; i < MO; i++) begin
      m0_stb = (i % 2 == 0); m1_stb = (i % 2 == 1); m0_we = 0; m1_we = 0; rand_fields();
      cycle();
    end
    m0_stb = 1; m1_stb = 1;
    cycle();
    chk("t4_full", dut_grant, -1);
    wb_ack = 1; wb_rdata = {4{32'hCAFE_0001}};
    cycle();
    chk("t4_pop_accept", dut_grant, 0);
    m0_stb = 0; m1_stb = 0;
    for (int i = 0; i < MO; i++) begin
      wb_rdata = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    wb_ack = 0;
    cycle();

    // Stray ack with nothing outstanding
    do_reset();
    wb_ack = 1;
    cycle();
    wb_ack = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_err_sticky", err, 1'b1);
      chk("t5_no_ack", {m0_ack, m1_ack}, 2'b00);
    end
    do_reset();
    chk("t5_err_clear", err, 1'b0);

    // Reset with transactions in flight discards them
    for (int i = 0; i < 3; i++) begin
      m0_stb = 1; m1_stb = 1; rand_fields();
      cycle();
    end
    idle();
    rst = 1;
    cycle();
    chk("t6_stb", wb_stb, 1'b0);
    chk("t6_cyc", wb_cyc, 1'b0);
    rst = 0;
    wb_ack = 1;
    cycle();
    wb_ack = 0;
    chk("t6_err", err, 1'b1);
    chk("t6_no_ack", {m0_ack, m1_ack}, 2'b00);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      m0_stb = ($urandom_range(0, 2) != 0);
      m1_stb = ($urandom_range(0, 2) != 0);
      wb_stall = ($urandom_range(0, 3) == 0);
      wb_ack = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      cycle();
    end
    idle();
    while (q.size() > 0) begin
      wb_ack = 1;
      cycle();
    end
    wb_ack = 0;
    cycle();
    chk("rand_drained", wb_cyc, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
